// File: rtl/deadtime_gen.sv
// Multi-channel programmable dead-time inserter for half-bridge gate drive.
// Blanks both drives after any command edge and blocks/latches shoot-through.
module deadtime_gen #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned DT_W        = 6,
  parameter bit          FAULT_LATCH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DT_W-1:0]   dead_time,
  input  logic              fault_clr,
  input  logic [NUM_CH-1:0] high_in,
  input  logic [NUM_CH-1:0] low_in,
  output logic [NUM_CH-1:0] high_out,
  output logic [NUM_CH-1:0] low_out,
  output logic [NUM_CH-1:0] in_dead,
  output logic [NUM_CH-1:0] fault
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DEAD = 1'b1;

  logic [NUM_CH-1:0]           state;
  logic [NUM_CH-1:0]           stateNext;
  logic [NUM_CH-1:0][DT_W-1:0] cnt;
  logic [NUM_CH-1:0][DT_W-1:0] cntNext;
  logic [NUM_CH-1:0][DT_W-1:0] dtL;
  logic [NUM_CH-1:0][DT_W-1:0] dtLNext;
  logic [NUM_CH-1:0]           prevHi;
  logic [NUM_CH-1:0]           prevLo;
  logic                        enPrev;

  logic [NUM_CH-1:0] chg;
  logic [NUM_CH-1:0] st;
  logic              enRise;
  logic [NUM_CH-1:0] deadNext;
  logic [NUM_CH-1:0] blank;
  logic [NUM_CH-1:0] faultNext;

  assign chg       = (high_in ^ prevHi) | (low_in ^ prevLo);
  assign st        = high_in & low_in;
  assign enRise    = enable & ~enPrev;
  assign faultNext = (fault & ~{NUM_CH{fault_clr}}) | (st & {NUM_CH{enable}});

  // Per-channel next state; enable edge restarts every channel like a command edge.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    dtLNext   = dtL;
    deadNext  = '0;
    blank     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!enable) begin
        stateNext[i] = IDLE;
        cntNext[i]   = '0;
      end else if (enRise || chg[i]) begin
        stateNext[i] = (dead_time != '0) ? DEAD : IDLE;
        cntNext[i]   = dead_time;
        dtLNext[i]   = dead_time;
      end else if (state[i] == DEAD) begin
        if (cnt[i] <= DT_W'(1)) begin
          stateNext[i] = IDLE;
          cntNext[i]   = '0;
        end else begin
          cntNext[i] = cnt[i] - DT_W'(1);
        end
      end
      deadNext[i] = (stateNext[i] == DEAD);
      blank[i]    = !enable || deadNext[i] || st[i] ||
                    (FAULT_LATCH && (fault[i] || st[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= '0;
      cnt      <= '0;
      dtL      <= '0;
      prevHi   <= '0;
      prevLo   <= '0;
      enPrev   <= 1'b0;
      high_out <= '0;
      low_out  <= '0;
      in_dead  <= '0;
      fault    <= '0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      dtL      <= dtLNext;
      prevHi   <= high_in;
      prevLo   <= low_in;
      enPrev   <= enable;
      high_out <= high_in & ~blank;
      low_out  <= low_in & ~blank;
      in_dead  <= deadNext;
      fault    <= faultNext;
    end
  end

endmodule

// File: tb/tb_deadtime_gen.sv
// Scoreboard bench for deadtime_gen: timestamp-based reference model feeds an
// expectation queue that a separate monitor drains once per clock.
module tb_deadtime_gen;

  localparam int unsigned NUM_CH      = 3;
  localparam int unsigned DT_W        = 6;
  localparam bit          FAULT_LATCH = 1'b1;

  typedef struct packed {
    logic [NUM_CH-1:0] hi;
    logic [NUM_CH-1:0] lo;
    logic [NUM_CH-1:0] dead;
    logic [NUM_CH-1:0] flt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic [DT_W-1:0]   dead_time = '0;
  logic              fault_clr = 1'b0;
  logic [NUM_CH-1:0] high_in = '0;
  logic [NUM_CH-1:0] low_in = '0;
  logic [NUM_CH-1:0] high_out, low_out, in_dead, fault;

  deadtime_gen #(.NUM_CH(NUM_CH), .DT_W(DT_W), .FAULT_LATCH(FAULT_LATCH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .dead_time(dead_time),
    .fault_clr(fault_clr), .high_in(high_in), .low_in(low_in),
    .high_out(high_out), .low_out(low_out), .in_dead(in_dead), .fault(fault)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  // Stimulus state (what the bench wants on the pins next cycle)
  logic [NUM_CH-1:0] curH = '0, curL = '0;
  logic              curEn = 1'b0, curClr = 1'b0, curRst = 1'b0;
  logic [DT_W-1:0]   curDt = '0;

  // Reference model: each channel is blanked while edge index < blankEnd
  int                mCyc = 0;
  int                blankEnd [NUM_CH];
  logic [NUM_CH-1:0] mPrevH = '0, mPrevL = '0, mFault = '0;
  logic              mEnPrev = 1'b0;

  task automatic chk(input string name, input logic [NUM_CH-1:0] act, input logic [NUM_CH-1:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, req);
  endtask

  // Drive n cycles with the current stimulus, pushing the model's prediction for each edge
  task automatic tick(input int n);
    exp_t e;
    logic [NUM_CH-1:0] chg, st;
    logic dead, zero;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      high_in = curH; low_in = curL; enable = curEn;
      dead_time = curDt; fault_clr = curClr; rst = curRst;
      e = '0;
      if (curRst) begin
        mPrevH = '0; mPrevL = '0; mFault = '0; mEnPrev = 1'b0;
        for (int i = 0; i < NUM_CH; i++) blankEnd[i] = 0;
      end else begin
        chg = (curH ^ mPrevH) | (curL ^ mPrevL);
        st  = curH & curL;
        for (int i = 0; i < NUM_CH; i++) begin
          if (!curEn) blankEnd[i] = 0;
          else if ((curEn && !mEnPrev) || chg[i]) blankEnd[i] = mCyc + int'(curDt);
          dead = (mCyc < blankEnd[i]);
          zero = !curEn || dead || st[i] || (FAULT_LATCH && (mFault[i] || st[i]));
          e.hi[i]   = zero ? 1'b0 : curH[i];
          e.lo[i]   = zero ? 1'b0 : curL[i];
          e.dead[i] = dead;
        end
        mFault  = (curClr ? '0 : mFault) | (curEn ? st : '0);
        mPrevH  = curH; mPrevL = curL; mEnPrev = curEn;
      end
      e.flt = mFault;
      q.push_back(e);
      mCyc++;
      curClr = 1'b0;
    end
  endtask

  // Monitor: DUT presents a registered result every edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("high_out", high_out, e.hi);
        chk("low_out", low_out, e.lo);
        chk("in_dead", in_dead, e.dead);
        chk("fault", fault, e.flt);
      end
    end
  end

  initial begin
    int ch, r;
    for (int i = 0; i < NUM_CH; i++) blankEnd[i] = 0;

    // Reset and 1-cycle pass-through
    curRst = 1'b1; tick(2);
    curRst = 1'b0; curEn = 1'b1; curDt = '0; tick(3);
    curH[0] = 1'b1; tick(3);

    // Basic dead time
    curDt = DT_W'(4); curH[1] = 1'b1; tick(6);

    // Retrigger with a mid-dead dead_time change
    curDt = DT_W'(8); curL[2] = 1'b1; tick(10);
    curL[2] = 1'b0; tick(3);
    curH[2] = 1'b1; tick(2);
    curDt = DT_W'(2); tick(10);

    // Shoot-through latch and clear
    curDt = '0; curL[0] = 1'b1; tick(1);
    curL[0] = 1'b0; tick(3);
    curClr = 1'b1; tick(3);
    curL[0] = 1'b1; curClr = 1'b1; tick(1);
    curL[0] = 1'b0; tick(2);
    curClr = 1'b1; tick(2);

    // Enable re-arm
    curEn = 1'b0; tick(5);
    curEn = 1'b1; curDt = DT_W'(3); tick(6);

    // Mid-operation reset during dead time
    curDt = DT_W'(6); curH[1] = 1'b0; curL[1] = 1'b1; tick(2);
    curRst = 1'b1; curH = '0; curL = '0; tick(1);
    curRst = 1'b0; tick(4);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        ch = int'($urandom_range(0, NUM_CH - 1));
        r  = int'($urandom_range(0, 19));
        curH[ch] = (r == 0) || (r < 7);
        curL[ch] = (r == 0) || (r >= 7 && r < 13);
      end
      if ($urandom_range(0, 39) == 0) curDt = DT_W'($urandom_range(0, 12));
      if (curEn ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 7) == 0)) curEn = ~curEn;
      if ($urandom_range(0, 29) == 0) curClr = 1'b1;
      curRst = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    curRst = 1'b0;

    @(posedge clk);
    #2;
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: %0d entries left, expected 0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/deadtime_gen.md
Name: deadtime_gen

Overview:
Multi-channel, programmable dead-time inserter for half-bridge gate drive. Per channel it takes a high-side/low-side command pair and forces both outputs low for a run-time programmable number of cycles after any command edge. It also blocks shoot-through (both commands high) and latches a per-channel fault. It sits between the PWM generator and the gate-drive pins and is the multi-phase, programmable successor to the fixed 32-cycle single-pair non-overlap block.

Parameters:
NUM_CH, 3, number of independent half-bridge channels (1..8)
DT_W, 6, width of dead_time; maximum dead time 2^DT_W-1 cycles
FAULT_LATCH, 1, 1 = a shoot-through fault holds the channel's outputs low until fault_clr; 0 = only the offending cycles are masked

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  global enable; low forces all outputs low
dead_time  in  DT_W  dead-time length in cycles, shared by all channels; 0 = no dead time
fault_clr  in  1  single-cycle pulse, clears all sticky fault bits
high_in  in  NUM_CH  high-side command, one bit per channel
low_in  in  NUM_CH  low-side command, one bit per channel
high_out  out  NUM_CH  registered high-side drive
low_out  out  NUM_CH  registered low-side drive
in_dead  out  NUM_CH  1 while the channel is in DEAD state
fault  out  NUM_CH  sticky shoot-through flag per channel

Behaviour:
- Reset (rst=1 at an edge): high_out, low_out, in_dead and fault are 0. States go to IDLE, counters to 0. prev_hi/prev_lo command registers go to 0. The enable-history register goes to 0.
- Per-channel change detect: chg = (high_in^prev_hi) | (low_in^prev_lo). prev_* registers sample the commands every cycle, regardless of enable.
- Shoot-through detect: st = high_in & low_in.
- Per-channel FSM with 2 states, IDLE and DEAD. It has a DT_W-bit down counter and a DT_W-bit latched length dt_l.
  - IDLE:
    - If chg and dead_time!=0: go to DEAD, cnt<=dead_time, dt_l<=dead_time.
    - If chg and dead_time==0: stay in IDLE.
  - DEAD:
    - If chg: restart with cnt<=dead_time, and re-sample dt_l.
    - Else if cnt==1: go to IDLE.
    - Else: cnt<=cnt-1.
  - A dead_time change made while in DEAD does not affect the running count. It takes effect only at the next change.
- Enable rising edge (enable=1, previous enable=0): every channel is forced to DEAD with cnt<=dead_time. If dead_time==0, channels go to IDLE instead. This event overrides chg.
- Enable low: all outputs are driven 0 and FSMs are held in IDLE with cnt=0. Fault bits keep their value.
- Output register, evaluated per channel with the highest-priority condition first:
  1. Outputs become 0 if: !enable, or next_state==DEAD, or st, or (FAULT_LATCH && (fault || st)).
  2. Otherwise high_out<=high_in and low_out<=low_in.
  - Latency: pass-through (dead_time=0) is 1 cycle.
  - If a change is sampled at edge t with dead_time=D>0, outputs are 0 for edges t..t+D-1. The new command appears at edge t+D.
- in_dead is the registered state==DEAD. It asserts on the edge where DEAD is entered.
- Fault bits:
  - fault[i]<=1 on any edge where st[i] and enable.
  - fault_clr clears all bits.
  - If fault_clr and st occur on the same edge, the set wins.
  - The fault path does not disturb FSM timing.
- Counter arithmetic: unsigned DT_W bits. cnt never decrements below 1 in DEAD and never wraps.

Test Plan:
1. Reset, then 1 cycle pass-through check: rst=1 for 2 cycles gives all outputs 0. With dead_time=0 and enable=1, high_in[0] rises before edge 10, so high_out[0]=1 from edge 10 and in_dead stays 0.
2. Basic dead time: dead_time=4, high_in[1] rises before edge 20. Then high_out[1]=0 at edges 20..23, =1 at edge 24. in_dead[1]=1 at edges 20..23.
3. Retrigger: dead_time=8, low_in[2] falls before edge 30 and high_in[2] rises before edge 33. Both outputs stay 0 through edge 40, and high_out[2]=1 at edge 41. Changing dead_time to 2 at edge 35 does not shorten this.
4. Shoot-through with FAULT_LATCH=1: high_in[0]=low_in[0]=1 for 1 cycle. Both outputs stay 0 and fault[0]=1. Outputs remain 0 after the commands return to legal values, until a fault_clr pulse. The cycle after clear, outputs follow the commands. fault_clr coincident with st leaves fault=1.
5. Enable re-arm: enable is low for 5 cycles and all outputs are 0. enable rises with dead_time=3 and commands steady. All channels show in_dead=1 and outputs 0 for 3 cycles, then follow the commands.
6. Mid-operation reset: rst asserted during DEAD with cnt=5. Next edge all outputs are 0, in_dead=0 and fault=0. After rst drops with steady zero commands, no dead period occurs.
